// File: rtl/calc_pkg.sv
// Shared types and defaults for the calc accumulator and its command driver.
package calc_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  // Operation select as presented on {btnl, btnr, btnd}
  typedef enum logic [2:0] {
    OP_LSR  = 3'b000,
    OP_LSL  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MULT = 3'b100,
    OP_NOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_XOR  = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_CAPTURE,
    ST_RESP
  } drv_state_e;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO with asynchronous reset and full/empty flags.
module calc_cmd_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             avail
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && avail;
  assign rdata   = mem[rd_ptr];

  // Storage: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Read-side valid flag: a freshly written entry becomes visible one cycle
  // after its write, while a pop retires visibility immediately. This keeps a
  // word from being pushed and popped in the same cycle and never overruns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) avail <= 1'b0;
    else     avail <= ((count - (do_pop ? ONE : '0)) != '0);
  end

endmodule

// File: rtl/calc_cmd_driver.sv
// Replays queued commands onto calc's button/switch interface and returns
// the accumulator value after each command over a valid/ready stream.
module calc_cmd_driver
  import calc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              btnac,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clr,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_operand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              calc_btnc,
  output logic              calc_btnac,
  output logic              calc_btnl,
  output logic              calc_btnr,
  output logic              calc_btnd,
  output logic [DATA_W-1:0] calc_sw,
  input  logic [DATA_W-1:0] calc_led
);

  localparam int unsigned CMD_W = 1 + 3 + DATA_W;

  drv_state_e        state;
  drv_state_e        state_nxt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_avail;
  logic              pop;
  logic [CMD_W-1:0]  head;
  logic              hold_clr;
  alu_op_e           hold_op;
  logic [DATA_W-1:0] hold_operand;

  calc_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (btnac),
    .push  (cmd_valid),
    .wdata ({cmd_clr, cmd_op, cmd_operand}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .avail (fifo_avail)
  );

  // State register
  always_ff @(posedge clk or posedge btnac) begin
    if (btnac) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: fixed one-cycle SETUP/STROBE/CAPTURE, RESP waits for handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (fifo_avail) state_nxt = ST_SETUP;
      ST_SETUP:   state_nxt = ST_STROBE;
      ST_STROBE:  state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs: FIFO control, status and the all-clear strobe
  always_comb begin
    pop        = (state == ST_IDLE) && fifo_avail;
    cmd_ready  = !fifo_full;
    busy       = !fifo_empty || (state != ST_IDLE);
    calc_btnac = btnac || ((state == ST_STROBE) && hold_clr);
  end

  // Holding registers: loaded on pop, they also drive calc's op/sw so those
  // keep their last value through IDLE and RESP
  always_ff @(posedge clk or posedge btnac) begin
    if (btnac) begin
      hold_clr     <= 1'b0;
      hold_op      <= OP_LSR;
      hold_operand <= '0;
    end else if (pop) begin
      hold_clr     <= head[CMD_W-1];
      hold_op      <= alu_op_e'(head[DATA_W +: 3]);
      hold_operand <= head[DATA_W-1:0];
    end
  end

  assign {calc_btnl, calc_btnr, calc_btnd} = hold_op;
  assign calc_sw = hold_operand;

  // Registered load strobe: high for exactly the STROBE cycle of a non-clear command
  always_ff @(posedge clk or posedge btnac) begin
    if (btnac) calc_btnc <= 1'b0;
    else       calc_btnc <= (state_nxt == ST_STROBE) && !hold_clr;
  end

  // Response register: capture led as CAPTURE closes, hold until handshake
  always_ff @(posedge clk or posedge btnac) begin
    if (btnac) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (state_nxt == ST_RESP);
      if (state == ST_CAPTURE) rsp_data <= calc_led;
    end
  end

endmodule
